// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and helpers shared by the parameterised FIFO files.
//   FIFO_MODE_STD  - registered read; data appears the cycle after DEQ
//   FIFO_MODE_FWFT - first-word-fall-through; head word is always presented
//   clog2()        - ceiling log2 for sizing pointer and count fields
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to encode 0 .. value-1. clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: ring-buffer position counter for a FIFO of arbitrary depth.
// The counter advances by one when inc_i is high and wraps from DEPTH-1 to 0.
// The wrap is detected by comparing against DEPTH-1, so DEPTH does not have
// to be a power of two.
// Ports:
//   CLK    in   clock, rising edge
//   RST_X  in   asynchronous active-low reset (pointer -> 0)
//   inc_i  in   advance the pointer this cycle
//   ptr_o  out  current position, W_POS bits
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int W_POS = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             inc_i,
    output logic [W_POS-1:0] ptr_o
);

    localparam logic [W_POS-1:0] LAST_POS = W_POS'(DEPTH - 1);

    logic [W_POS-1:0] ptr_q;
    logic [W_POS-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = (ptr_q == LAST_POS) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO of arbitrary depth with standard or
// first-word-fall-through read, occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow error flags.
// Ports:
//   CLK           in   clock, rising edge
//   RST_X         in   asynchronous active-low reset (contents discarded)
//   ENQ, DIN      in   enqueue request and its data
//   DEQ           in   dequeue request
//   CLR_ERR       in   synchronous clear of OVERFLOW / UNDERFLOW
//   DOUT          out  read data
//   DOUT_VALID    out  DOUT holds a valid word this cycle
//   EMPTY, FULL   out  COUNT == 0 / COUNT == DEPTH
//   ALMOST_EMPTY  out  COUNT <= AE_LEVEL
//   ALMOST_FULL   out  COUNT >= AF_LEVEL
//   COUNT         out  current occupancy
//   OVERFLOW      out  sticky: an ENQ was rejected
//   UNDERFLOW     out  sticky: a DEQ was rejected
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 5,
    parameter int FWFT     = FIFO_MODE_STD,
    parameter int AF_LEVEL = 4,
    parameter int AE_LEVEL = 1,
    localparam int W_CNT   = clog2(DEPTH + 1),
    localparam int W_POS   = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic [WIDTH-1:0] DIN,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_EMPTY,
    output logic             ALMOST_FULL,
    output logic [W_CNT-1:0] COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    generate
        if (!(DEPTH >= 2 && AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH))
        begin : g_bad_params
            $error("param_fifo: need DEPTH>=2 and 0<=AE_LEVEL<AF_LEVEL<=DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [W_CNT-1:0] count_q;
    logic [W_CNT-1:0] count_d;
    logic [W_POS-1:0] head_q;
    logic [W_POS-1:0] tail_q;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    logic empty;
    logic full;
    logic deq_ok;
    logic enq_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == W_CNT'(DEPTH));

    // A full FIFO still accepts a write when a read frees a slot in the same
    // cycle; an empty FIFO never serves a read, even alongside a write.
    assign deq_ok = DEQ & ~empty;
    assign enq_ok = ENQ & (~full | deq_ok);

    fifo_ptr #(
        .DEPTH (DEPTH),
        .W_POS (W_POS)
    ) u_head (
        .CLK   (CLK),
        .RST_X (RST_X),
        .inc_i (deq_ok),
        .ptr_o (head_q)
    );

    fifo_ptr #(
        .DEPTH (DEPTH),
        .W_POS (W_POS)
    ) u_tail (
        .CLK   (CLK),
        .RST_X (RST_X),
        .inc_i (enq_ok),
        .ptr_o (tail_q)
    );

    // Storage is deliberately not reset. When the FIFO is full, head and
    // tail address the same slot; the read sees the old word because the
    // write only lands at the clock edge.
    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            mem[tail_q] <= DIN;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq_ok, deq_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A new error event in the same cycle as CLR_ERR keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q  & ~CLR_ERR) | (ENQ & full & ~deq_ok);
        underflow_d = (underflow_q & ~CLR_ERR) | (DEQ & empty);
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented combinationally; DEQ consumes it.
            assign DOUT       = mem[head_q];
            assign DOUT_VALID = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic [WIDTH-1:0] dout_d;
            logic             dout_valid_q;

            // Idle cycles drive zero so downstream never sees stale data.
            assign dout_d = deq_ok ? mem[head_q] : '0;

            always_ff @(posedge CLK or negedge RST_X) begin
                if (!RST_X) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= deq_ok;
                end
            end

            assign DOUT       = dout_q;
            assign DOUT_VALID = dout_valid_q;
        end
    endgenerate

    assign EMPTY        = empty;
    assign FULL         = full;
    assign ALMOST_EMPTY = (count_q <= W_CNT'(AE_LEVEL));
    assign ALMOST_FULL  = (count_q >= W_CNT'(AF_LEVEL));
    assign COUNT        = count_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo. A standard-read instance and an FWFT instance share
// the same stimulus. Each dequeue that should return data pushes the
// hand-computed word into a per-instance queue; monitor processes pop and
// compare whenever an instance presents a word.
module tb_param_fifo;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        ENQ;
    logic        DEQ;
    logic        CLR_ERR;
    logic [31:0] DIN;

    logic [31:0] s_dout, f_dout;
    logic        s_valid, f_valid;
    logic        s_empty, f_empty, s_full, f_full;
    logic        s_ae, f_ae, s_af, f_af;
    logic [2:0]  s_count, f_count;
    logic        s_ovf, f_ovf, s_udf, f_udf;

    int errors = 0;
    int checks = 0;
    logic [31:0] q_std[$];
    logic [31:0] q_fwft[$];

    always #5 CLK = ~CLK;

    param_fifo #(.WIDTH(32), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_std (
        .CLK(CLK), .RST_X(RST_X), .ENQ(ENQ), .DEQ(DEQ), .DIN(DIN), .CLR_ERR(CLR_ERR),
        .DOUT(s_dout), .DOUT_VALID(s_valid), .EMPTY(s_empty), .FULL(s_full),
        .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af), .COUNT(s_count),
        .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
    );

    param_fifo #(.WIDTH(32), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_fwft (
        .CLK(CLK), .RST_X(RST_X), .ENQ(ENQ), .DEQ(DEQ), .DIN(DIN), .CLR_ERR(CLR_ERR),
        .DOUT(f_dout), .DOUT_VALID(f_valid), .EMPTY(f_empty), .FULL(f_full),
        .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af), .COUNT(f_count),
        .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected flags follow from the occupancy: DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
    task automatic check_state(input string tag, input int c, input logic ovf, input logic udf);
        logic [2:0] ec;
        ec = 3'(c);
        check({tag, " std count"}, 32'(s_count), 32'(ec));
        check({tag, " std empty"}, 32'(s_empty), 32'(c == 0));
        check({tag, " std full"},  32'(s_full),  32'(c == 5));
        check({tag, " std ae"},    32'(s_ae),    32'(c <= 1));
        check({tag, " std af"},    32'(s_af),    32'(c >= 4));
        check({tag, " std ovf"},   32'(s_ovf),   32'(ovf));
        check({tag, " std udf"},   32'(s_udf),   32'(udf));
        check({tag, " fwft count"}, 32'(f_count), 32'(ec));
        check({tag, " fwft empty"}, 32'(f_empty), 32'(c == 0));
        check({tag, " fwft full"},  32'(f_full),  32'(c == 5));
        check({tag, " fwft ae"},    32'(f_ae),    32'(c <= 1));
        check({tag, " fwft af"},    32'(f_af),    32'(c >= 4));
        check({tag, " fwft ovf"},   32'(f_ovf),   32'(ovf));
        check({tag, " fwft udf"},   32'(f_udf),   32'(udf));
        check({tag, " fwft valid"}, 32'(f_valid), 32'(c != 0));
    endtask

    // One clock of stimulus. exp_pop marks a dequeue that must return exp_data.
    task automatic op(input logic enq, input logic deq, input logic [31:0] din,
                      input logic clr, input logic exp_pop, input logic [31:0] exp_data);
        ENQ = enq; DEQ = deq; DIN = din; CLR_ERR = clr;
        if (exp_pop) begin
            q_std.push_back(exp_data);
            q_fwft.push_back(exp_data);
        end
        @(posedge CLK);
        #1;
        ENQ = 1'b0; DEQ = 1'b0; DIN = '0; CLR_ERR = 1'b0;
    endtask

    // Standard mode: every valid cycle pops; idle cycles must show zero.
    always @(negedge CLK) begin
        if (RST_X === 1'b1) begin
            if (s_valid) begin
                if (q_std.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL std pop: got %0h with no word expected", s_dout);
                end else begin
                    logic [31:0] e;
                    e = q_std.pop_front();
                    $display("std  pop data=%0d expected=%0d", s_dout, e);
                    check("std dout", s_dout, e);
                end
            end else begin
                check("std idle dout", s_dout, 32'h0);
            end
        end
    end

    // FWFT mode: the shown word is consumed when DEQ is high with DOUT_VALID.
    always @(negedge CLK) begin
        if (RST_X === 1'b1 && DEQ && f_valid) begin
            if (q_fwft.size() == 0) begin
                checks++; errors++;
                $display("FAIL fwft pop: got %0h with no word expected", f_dout);
            end else begin
                logic [31:0] e;
                e = q_fwft.pop_front();
                $display("fwft pop data=%0d expected=%0d", f_dout, e);
                check("fwft dout", f_dout, e);
            end
        end
    end

    initial begin
        RST_X = 1'b0; ENQ = 1'b0; DEQ = 1'b0; CLR_ERR = 1'b0; DIN = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_state("reset", 0, 1'b0, 1'b0);
        check("reset std dout", s_dout, 32'h0);
        check("reset std valid", 32'(s_valid), 32'h0);
        RST_X = 1'b1;

        // FWFT fall-through of the first word, before any DEQ
        op(1, 0, 42, 0, 0, 0);
        check_state("ff42", 1, 0, 0);
        check("ff42 fwft dout", f_dout, 32'd42);
        op(0, 1, 0, 0, 1, 42);
        check_state("ff42 drained", 0, 0, 0);

        // Fill and drain
        for (int i = 0; i < 5; i++) begin
            op(1, 0, 32'(10 + i), 0, 0, 0);
            check_state("fill", i + 1, 0, 0);
        end
        check("fill fwft head", f_dout, 32'd10);
        for (int i = 0; i < 5; i++) begin
            op(0, 1, 0, 0, 1, 32'(10 + i));
            check_state("drain", 4 - i, 0, 0);
        end
        op(0, 0, 0, 0, 0, 0);

        // Pointer wrap
        for (int i = 0; i < 3; i++) op(1, 0, 32'(1 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 1, 32'(1 + i));
        for (int i = 0; i < 5; i++) op(1, 0, 32'(20 + i), 0, 0, 0);
        check_state("wrap full", 5, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 1, 32'(20 + i));
        op(0, 0, 0, 0, 0, 0);
        check_state("wrap done", 0, 0, 0);

        // Simultaneous ENQ/DEQ when full and when empty
        for (int i = 0; i < 5; i++) op(1, 0, 32'(30 + i), 0, 0, 0);
        op(1, 1, 99, 0, 1, 30);
        check_state("full enq+deq", 5, 0, 0);
        for (int i = 1; i < 5; i++) op(0, 1, 0, 0, 1, 32'(30 + i));
        op(0, 1, 0, 0, 1, 99);
        op(1, 1, 7, 0, 0, 0);
        check_state("empty enq+deq", 1, 0, 1);
        op(0, 1, 0, 0, 1, 7);
        check_state("pop 7", 0, 0, 1);
        op(0, 0, 0, 1, 0, 0);
        check_state("clr udf", 0, 0, 0);

        // Overflow handling and CLR_ERR priority
        for (int i = 0; i < 5; i++) op(1, 0, 32'(50 + i), 0, 0, 0);
        op(1, 0, 77, 0, 0, 0);
        check_state("overflow", 5, 1, 0);
        op(0, 0, 0, 1, 0, 0);
        check_state("clr ovf", 5, 0, 0);
        op(1, 0, 78, 1, 0, 0);
        check_state("ovf+clr", 5, 1, 0);
        op(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 1, 32'(50 + i));
        op(0, 0, 0, 0, 0, 0);
        check_state("ovf drained", 0, 0, 0);

        // Asynchronous reset mid-stream
        op(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) op(1, 0, 32'(60 + i), 0, 0, 0);
        check_state("pre-reset", 3, 0, 1);
        #2;
        RST_X = 1'b0;
        #1;
        check_state("async reset", 0, 0, 0);
        check("async reset std valid", 32'(s_valid), 32'h0);
        @(posedge CLK);
        #1;
        RST_X = 1'b1;
        op(0, 1, 0, 0, 0, 0);
        check_state("post-reset deq", 0, 0, 1);
        op(0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 0, 0);

        check("std queue leftover", 32'(q_std.size()), 32'h0);
        check("fwft queue leftover", 32'(q_fwft.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
